// File: rtl/delay_sched_pkg.sv
// Shared types and helpers for the delay scheduler: FSM state encoding,
// default widths and the delay clamp applied at grant time.
package delay_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int DEF_CBITS = 15;
    localparam int DEF_MAXD  = 20000;

    // A zero delay still takes one cycle; oversize delays saturate at maxd.
    function automatic int unsigned clamp_dly(input int unsigned d, input int unsigned maxd);
        if (d == 0)
            return 1;
        if (d > maxd)
            return maxd;
        return d;
    endfunction

endpackage

// File: rtl/delay_sched_rr_arb.sv
// Combinational round-robin picker: first set request strictly after ptr,
// scanning upward with wrap, so the last winner has lowest priority.
module rr_arb #(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            valid
);

    logic found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        valid   = |req;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(ptr) + i) % NREQ);
            end
        end
        gnt = valid ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/delay_sched.sv
// One programmable delay timer shared round-robin between NREQ requesters;
// grants with ack, counts the clamped delay, then pulses done to the owner.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CBITS = DEF_CBITS,
    parameter int MAXD  = DEF_MAXD,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    input  logic                  abort,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  aborted,
    output logic                  busy,
    output logic [IW-1:0]         owner,
    output logic [CBITS-1:0]      cnt
);

    // Handshake: req[i] is a level held until ack[i]; ack is a one-cycle,
    // one-hot pulse and the requester must drop req in that same cycle.
    // A req still high at the next arbitration edge counts as a new request.

    state_t            state_q, state_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [CBITS-1:0]  target_q, target_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [CBITS-1:0]  dly_g;
    logic              expire;
    logic              arb_edge;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .valid   (gnt_valid)
    );

    assign dly_g    = dly[gnt_idx*CBITS +: CBITS];
    assign expire   = (state_q == COUNT) && (cnt_q == target_q) && !abort;
    assign arb_edge = (state_q == IDLE) || expire;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        aborted_d = 1'b0;

        if (state_q == COUNT && abort) begin
            // Abort beats expiry and suppresses any grant at this edge.
            state_d   = IDLE;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end else begin
            if (expire)
                done_d = NREQ'(1) << owner_q;

            if (arb_edge && gnt_valid) begin
                state_d  = COUNT;
                cnt_d    = CBITS'(1);
                target_d = CBITS'(clamp_dly(32'(dly_g), MAXD));
                owner_d  = gnt_idx;
                ptr_d    = gnt_idx;
                ack_d    = gnt;
                err_d    = (32'(dly_g) > 32'(MAXD));
            end else if (expire) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (state_q == COUNT) begin
                cnt_d = cnt_q + CBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            owner_q   <= '0;
            ptr_q     <= IW'(NREQ - 1);
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign err     = err_q;
    assign aborted = aborted_q;
    assign busy    = (state_q == COUNT);
    assign owner   = owner_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboard bench for delay_sched: each scenario pushes its predicted
// ack/done/aborted events (with cycle stamps) and a monitor pops them.
module tb_delay_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 15;
    localparam int MAXD  = 20000;
    localparam int IW    = $clog2(NREQ);
    localparam int W     = 38;

    localparam int K_ABORT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ACK   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] dly = '0;
    logic                  abort = 1'b0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  aborted;
    logic                  busy;
    logic [IW-1:0]         owner;
    logic [CBITS-1:0]      cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c;

    logic [W-1:0] exp_q[$];

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAXD(MAXD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dly     (dly),
        .abort   (abort),
        .ack     (ack),
        .done    (done),
        .err     (err),
        .aborted (aborted),
        .busy    (busy),
        .owner   (owner),
        .cnt     (cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk_ev(input int cy, input int kind, input int idx, input logic e);
        return {32'(cy), 2'(kind), 3'(idx), e};
    endfunction

    task automatic obs_event(input logic [W-1:0] ev);
        if (exp_q.size() == 0)
            check("unexpected_event", 64'(ev), 64'd0);
        else
            check("event", 64'(ev), 64'(exp_q.pop_front()));
    endtask

    // Monitor: within a cycle events are reported aborted, done, then ack.
    always @(negedge clk) begin
        if (rst) begin
            if (aborted)
                obs_event(mk_ev(cyc, K_ABORT, 0, 1'b0));
            for (int i = 0; i < NREQ; i++)
                if (done[i]) obs_event(mk_ev(cyc, K_DONE, i, 1'b0));
            for (int i = 0; i < NREQ; i++)
                if (ack[i]) obs_event(mk_ev(cyc, K_ACK, i, err));
            if (err && ack == '0)
                check("err_without_ack", 64'(err), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dly(input int i, input int v);
        dly[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    task automatic push(input int cy, input int kind, input int idx, input logic e);
        exp_q.push_back(mk_ev(cy, kind, idx, e));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            step(1);
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},     64'(ack),     64'd0);
        check({tag, "_done"},    64'(done),    64'd0);
        check({tag, "_err"},     64'(err),     64'd0);
        check({tag, "_aborted"}, 64'(aborted), 64'd0);
        check({tag, "_busy"},    64'(busy),    64'd0);
        check({tag, "_owner"},   64'(owner),   64'd0);
        check({tag, "_cnt"},     64'(cnt),     64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset");
        step(2);
        rst = 1'b1;
        step(2);

        // Round-robin: all four request at once, each drops on its ack.
        for (int i = 0; i < NREQ; i++) set_dly(i, 3);
        c = cyc;
        push(c + 1,  K_ACK, 0, 1'b0);
        push(c + 4,  K_DONE, 0, 1'b0);
        push(c + 4,  K_ACK, 1, 1'b0);
        push(c + 7,  K_DONE, 1, 1'b0);
        push(c + 7,  K_ACK, 2, 1'b0);
        push(c + 10, K_DONE, 2, 1'b0);
        push(c + 10, K_ACK, 3, 1'b0);
        push(c + 13, K_DONE, 3, 1'b0);
        req = 4'b1111;
        step(1); req = 4'b1110;
        step(3); req = 4'b1100;
        step(3); req = 4'b1000;
        step(3); req = 4'b0000;
        wait_drain("rr_drain", 50);
        check("rr_owner", 64'(owner), 64'd3);

        // Single request, D=5: cnt walks 1..5, busy drops with done.
        set_dly(0, 5);
        c = cyc;
        push(c + 1, K_ACK, 0, 1'b0);
        push(c + 6, K_DONE, 0, 1'b0);
        req = 4'b0001;
        step(1); req = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            check("single_cnt",  64'(cnt),  64'((i <= 5) ? i : 0));
            check("single_busy", 64'(busy), 64'(i <= 5));
            if (i < 6) step(1);
        end
        wait_drain("single_drain", 20);
        check("single_owner", 64'(owner), 64'd0);

        // Oversize delay clamps to MAXD and flags err.
        set_dly(2, 30000);
        c = cyc;
        push(c + 1,        K_ACK, 2, 1'b1);
        push(c + 1 + MAXD, K_DONE, 2, 1'b0);
        req = 4'b0100;
        step(1); req = 4'b0000;
        wait_drain("clamp_drain", MAXD + 100);

        // Zero delay behaves as one cycle without err.
        set_dly(1, 0);
        c = cyc;
        push(c + 1, K_ACK, 1, 1'b0);
        push(c + 2, K_DONE, 1, 1'b0);
        req = 4'b0010;
        step(1); req = 4'b0000;
        wait_drain("zero_drain", 20);

        // Abort 10 cycles into a 100-cycle delay.
        set_dly(0, 100);
        c = cyc;
        push(c + 1,  K_ACK, 0, 1'b0);
        push(c + 12, K_ABORT, 0, 1'b0);
        req = 4'b0001;
        step(1); req = 4'b0000;
        step(10); abort = 1'b1;
        step(1); abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cnt",  64'(cnt),  64'd0);
        wait_drain("abort_drain", 20);

        // Abort on the expiry edge with a pending request: no done, no grant
        // at that edge, grant on the following one.
        set_dly(0, 4);
        set_dly(1, 2);
        c = cyc;
        push(c + 1, K_ACK, 0, 1'b0);
        push(c + 5, K_ABORT, 0, 1'b0);
        push(c + 6, K_ACK, 1, 1'b0);
        push(c + 8, K_DONE, 1, 1'b0);
        req = 4'b0001;
        step(1); req = 4'b0000;
        step(3); abort = 1'b1; req = 4'b0010;
        step(1); abort = 1'b0;
        check("abort_exp_busy", 64'(busy), 64'd0);
        step(1); req = 4'b0000;
        wait_drain("abort_exp_drain", 20);

        // Abort while idle has no effect.
        abort = 1'b1;
        step(1); abort = 1'b0;
        step(2);
        check("idle_abort_busy", 64'(busy), 64'd0);

        // Reset in the middle of a count, then priority restarts at 0.
        set_dly(3, 200);
        c = cyc;
        push(c + 1, K_ACK, 3, 1'b0);
        req = 4'b1000;
        step(1); req = 4'b0000;
        step(49);
        check("midrst_cnt", 64'(cnt), 64'd50);
        rst = 1'b0;
        #1 check_reset_outputs("midrst");
        check("midrst_queue", 64'(exp_q.size()), 64'd0);
        step(2);
        rst = 1'b1;
        step(1);
        set_dly(1, 2);
        set_dly(3, 2);
        c = cyc;
        push(c + 1, K_ACK, 1, 1'b0);
        push(c + 3, K_DONE, 1, 1'b0);
        push(c + 3, K_ACK, 3, 1'b0);
        push(c + 5, K_DONE, 3, 1'b0);
        req = 4'b1010;
        step(1); req = 4'b1000;
        step(2); req = 4'b0000;
        wait_drain("postrst_drain", 20);

        // Held request: 1 stays high, 2 pulses once -> 1, 2, 1; dly1 changed
        // mid-count must not affect the running delay.
        set_dly(1, 3);
        set_dly(2, 3);
        c = cyc;
        push(c + 1,  K_ACK, 1, 1'b0);
        push(c + 4,  K_DONE, 1, 1'b0);
        push(c + 4,  K_ACK, 2, 1'b0);
        push(c + 7,  K_DONE, 2, 1'b0);
        push(c + 7,  K_ACK, 1, 1'b0);
        push(c + 10, K_DONE, 1, 1'b0);
        req = 4'b0110;
        step(4); req = 4'b0010;
        step(3); req = 4'b0000;
        step(1); set_dly(1, 50);
        wait_drain("held_drain", 30);
        check("held_owner", 64'(owner), 64'd1);
        check("held_busy",  64'(busy),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Shares one programmable delay timer between NREQ requesters.
- Each requester asks for a delay of D cycles. The block arbitrates round-robin, loads the timer, counts, then pulses done back to the owning requester.
- Sits in front of the delay/timeout datapath so several control FSMs can time events with a single CBITS-wide counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CBITS, 15, counter and delay-value width.
- MAXD, 20000, largest legal delay; larger requests are clamped to MAXD and flagged.
- IW, $clog2(NREQ), owner index width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  request level per requester; held until its ack.
- dly  in  NREQ*CBITS  requested delay; requester i uses bits [i*CBITS +: CBITS].
- abort  in  1  synchronous cancel of the running delay.
- ack  out  NREQ  one-cycle grant pulse, one-hot.
- done  out  NREQ  one-cycle expiry pulse, one-hot.
- err  out  1  one-cycle pulse with ack when the granted dly > MAXD.
- aborted  out  1  one-cycle pulse when a running delay is cancelled.
- busy  out  1  timer owned (state COUNT).
- owner  out  IW  index of the current or last owner.
- cnt  out  CBITS  current count; 0 when idle.

Behaviour:
- Reset (rst low, async): state=IDLE; cnt=0; target=0; owner=0; ack, done, err, aborted, busy all 0; round-robin pointer=NREQ-1, so requester 0 has first priority.
- States: IDLE, COUNT. All outputs registered.
- Arbitration edge: any rising edge in IDLE, or in COUNT when expiring (cnt==target and abort low).
  - At such an edge with req!=0: pick the first set req scanning from pointer+1 upward, with wrap.
  - Next cycle: state=COUNT, ack[g]=1, owner=g, pointer=g, cnt=1, target=max(1, min(dly[g], MAXD)).
  - err=1 in the ack cycle iff dly[g] > MAXD. D=0 is treated as D=1 with no err.
- Latency: ack appears in the cycle after req is sampled. With ack in cycle T, done[owner] pulses in cycle T+D exactly.
- COUNT, cnt != target: cnt increments by 1. No wrap is possible because target <= MAXD < 2^CBITS.
- Expiry (cnt == target at edge):
  - done[owner]=1 next cycle.
  - If a new grant happens at the same edge, state stays COUNT and done and ack coincide, possibly on different bits.
  - Otherwise state=IDLE and cnt=0.
- Throughput: back-to-back delays have zero idle cycles.
- abort high in COUNT: next cycle state=IDLE, cnt=0, aborted=1, no done.
  - Abort wins over simultaneous expiry.
  - No grant is made at that edge; arbitration resumes the following edge.
- abort in IDLE: ignored.
- Request sampling:
  - req is sampled only at arbitration edges.
  - A requester must drop req in its ack cycle. If req is still high at the next arbitration edge, it is a new request and is served after the other pending requesters.
  - dly[g] is sampled only at the grant edge; later changes are ignored.
- busy = (state == COUNT). owner holds its value in IDLE.
- Reset asserted mid-COUNT: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Package delay_sched_pkg: state enum (IDLE, COUNT), default CBITS/MAXD constants, and a clamp function min(max(1,d), MAXD).
- One sub-module rr_arb: combinational round-robin picker. Inputs req[NREQ] and pointer[IW]; outputs gnt one-hot and gnt_idx, valid=|req.
- Timer, FSM and output registers stay in delay_sched.

Test Plan:
- Single request: req[0]=1 with dly0=5 for one cycle -> ack[0] in T; done[0] in T+5; cnt shows 1..5; busy high T..T+4, low at T+5.
- Round-robin: req=4'b1111, all dly=3, each requester drops req on its ack -> ack order 0,1,2,3. Each done coincides with the next ack. Acks are 3 cycles apart.
- Clamp: dly2=30000 -> ack[2] with err=1; done[2] exactly 20000 cycles later. dly1=0 -> done 1 cycle after ack, err=0.
- Abort: dly=100; abort high 10 cycles after ack -> aborted=1 next cycle, busy=0, no done[0]. Abort at the exact expiry edge -> aborted only, no done.
- Reset mid-op: rst low during COUNT at cnt=50 -> all outputs 0 immediately. After release, req[3] and req[1] both high -> requester 1 wins first.
- Held request: req[1] stays high, req[2] pulses once -> order 1,2,1. Changing dly1 mid-count does not alter the running delay.
